fp_add_stall_ctrl: RTL and testbench
====================================

FP_ADD_STALL_CTRL -- requirements
Module: fp_add_stall_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 2: advancing cycles from operand presentation on pu_* to the matching result on pu_x.
REQ-002 SHALL have parameter DATA_W, default 32: IEEE single-precision word width.
REQ-003 SHALL have port aclk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port areset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: an upstream operand pair is offered.
REQ-006 SHALL have port in_ready, output, 1: the controller accepts the offered pair this cycle.
REQ-007 SHALL have port in_a, input, DATA_W: operand A (sign/exp/man packed, bit 31 = sign).
REQ-008 SHALL have port in_b, input, DATA_W: operand B, same packing as in_a.
REQ-009 SHALL have port in_rm, input, 3: rounding mode.
REQ-010 SHALL have port pu_a, output, DATA_W: operand A driven to the pipelined adder.
REQ-011 SHALL have port pu_b, output, DATA_W: operand B driven to the pipelined adder.
REQ-012 SHALL have port pu_rm, output, 3: rounding mode driven to the pipelined adder.
REQ-013 SHALL have port pu_stall, output, 1: drives the adder's astall; 1 freezes every adder stage.
REQ-014 SHALL have port pu_x, input, DATA_W: result from the adder's output register.
REQ-015 SHALL have port out_valid, output, 1: out_data holds a result.
REQ-016 SHALL have port out_ready, input, 1: downstream consumes out_data this cycle.
REQ-017 SHALL have port out_data, output, DATA_W: registered sum.
REQ-018 SHALL have port inflight, output, 4: count of accepted results not yet consumed downstream.

Function
REQ-019 SHALL drive pu_a/pu_b/pu_rm combinationally from in_a/in_b/in_rm.
REQ-020 SHALL keep a LAT-bit valid shift register vld[0..LAT-1] that advances only when pu_stall=0.
REQ-021 SHALL define the advance as vld[0] <= accept and vld[k] <= vld[k-1].
REQ-022 SHALL assert pu_stall = vld[LAT-1] & out_valid & ~out_ready, combinationally.
REQ-023 SHALL drive in_ready = ~pu_stall.
REQ-024 SHALL define accept = in_valid & in_ready.
REQ-025 SHALL hold all of vld unchanged while pu_stall=1, with no bubble collapsing.
REQ-026 SHALL load out_data <= pu_x and set out_valid when vld[LAT-1]=1 and pu_stall=0.
REQ-027 SHALL clear out_valid when out_valid & out_ready and no new load occurs.
REQ-028 SHALL, when a consume and a load occur in the same cycle, set out_valid=1 and give out_data the new value.
REQ-029 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-030 SHALL have latency: pair accepted in cycle t appears with out_valid=1 in cycle t+LAT+1 when no stall occurs.
REQ-031 SHALL deliver results in acceptance order with no loss and no duplication.
REQ-032 SHALL sustain a throughput of 1 result/cycle while out_ready=1.
REQ-033 SHALL update inflight as +1 on accept and -1 on consume (both together leave it unchanged); max value LAT+1; never wraps.

Reset
REQ-034 SHALL, with areset=1 at a clock edge, clear vld, set out_valid=0, out_data=0 and inflight=0.
REQ-035 SHALL, during reset, give in_ready=1 and pu_stall=0.
REQ-036 SHALL discard in-flight work on reset mid-operation; no stale result appears after reset.
REQ-037 SHALL ignore in_valid in the reset cycle.

Structure
REQ-038 SHALL take DATA_W, RM_W=3 and the rounding-mode encodings (RNE=0, RTZ=1, RUP=2, RDN=3) from shared package fp_add_pkg.
REQ-039 SHALL place the stall-gated valid shift register in sub-module fp_add_vld_pipe (ports aclk, areset, en, din, dout[LAT-1:0]).
REQ-040 SHALL NOT instantiate the adder; the bench or parent connects the adder to the pu_* ports.

Verification
REQ-041 SHALL cover single op: in_a=0x3F800000, in_b=0x40000000, rm=0 at t -> out_data=0x40400000, out_valid at t+3 (LAT=2).
REQ-042 SHALL cover streaming: 8 back-to-back pairs with out_ready=1 -> 8 in-order results on consecutive cycles; in_ready stays 1.
REQ-043 SHALL cover backpressure: out_ready=0 for 5 cycles with 3 ops issued -> pu_stall=1 once vld[1]=1, inflight=3, then 3 ordered results after release.
REQ-044 SHALL cover simultaneous consume and load: out_valid=1, out_ready=1, vld[1]=1 -> out_valid stays 1, out_data advances, inflight unchanged.
REQ-045 SHALL cover reset mid-operation: areset=1 with inflight=2 -> next cycle out_valid=0, inflight=0, and no result in the following 4 cycles.
REQ-046 SHALL cover special values: 0x7F800000 + 0xFF800000 -> out_data is NaN (exp=0xFF, man!=0); inflight returns to 0.

Source files
------------

// File: rtl/fp_add_pkg.sv
// Shared widths and rounding-mode encodings for the single-precision adder path.
package fp_add_pkg;

    localparam int DATA_W     = 32;
    localparam int RM_W       = 3;
    localparam int INFLIGHT_W = 4;

    typedef enum logic [RM_W-1:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RUP = 3'd2,
        RM_RDN = 3'd3
    } rm_e;

endpackage

// File: rtl/fp_add_vld_pipe.sv
// Valid-bit shadow of the adder pipeline; advances only on cycles the adder advances.
module fp_add_vld_pipe
    import fp_add_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic           en,
    input  logic           din,
    output logic [LAT-1:0] dout
);

    logic [LAT-1:0] vld_q;
    logic [LAT-1:0] vld_d;

    // NOTE: default every always_comb output before any branch so no path leaves it unassigned (latch).
    always_comb begin
        vld_d = vld_q;
        if (en) begin
            vld_d[0] = din;
            for (int k = 1; k < LAT; k++) begin
                vld_d[k] = vld_q[k-1];
            end
        end
    end

    // NOTE: state flops use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge aclk) begin
        if (areset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign dout = vld_q;

endmodule

// File: rtl/fp_add_stall_ctrl.sv
// Stall controller wrapping an external LAT-stage adder with a one-entry output register.
module fp_add_stall_ctrl
    import fp_add_pkg::*;
#(
    parameter int LAT    = 2,
    parameter int DATA_W = fp_add_pkg::DATA_W
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_a,
    input  logic [DATA_W-1:0]     in_b,
    input  logic [RM_W-1:0]       in_rm,
    output logic [DATA_W-1:0]     pu_a,
    output logic [DATA_W-1:0]     pu_b,
    output logic [RM_W-1:0]       pu_rm,
    output logic                  pu_stall,
    input  logic [DATA_W-1:0]     pu_x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [INFLIGHT_W-1:0] inflight
);

    logic [LAT-1:0]        vld;
    logic                  vld_unused;
    logic                  stall;
    logic                  accept;
    logic                  load;
    logic                  consume;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_W-1:0]     out_data_q,  out_data_d;
    logic [INFLIGHT_W-1:0] inflight_q,  inflight_d;

    assign pu_a  = in_a;
    assign pu_b  = in_b;
    assign pu_rm = in_rm;

    // Freeze only when the head result has nowhere to go; reset always releases the adder.
    assign stall    = ~areset & vld[LAT-1] & out_valid_q & ~out_ready;
    assign pu_stall = stall;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready & ~areset;
    assign load     = vld[LAT-1] & ~stall;
    assign consume  = out_valid_q & out_ready;

    fp_add_vld_pipe #(
        .LAT (LAT)
    ) u_vld_pipe (
        .aclk   (aclk),
        .areset (areset),
        .en     (~stall),
        .din    (accept),
        .dout   (vld)
    );

    // Inner stages only matter to the pipe itself.
    assign vld_unused = ^vld;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = pu_x;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({accept, consume})
            2'b10:   inflight_d = inflight_q + INFLIGHT_W'(1);
            2'b01:   inflight_d = inflight_q - INFLIGHT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            inflight_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            inflight_q  <= inflight_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign inflight  = inflight_q;

endmodule

// File: tb/tb_fp_add_stall_ctrl.sv
// Directed bench for fp_add_stall_ctrl with a behavioural 2-stage stallable adder on pu_*.
module tb_fp_add_stall_ctrl;
    import fp_add_pkg::*;

    logic        aclk      = 1'b0;
    logic        areset    = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_a      = 32'h0;
    logic [31:0] in_b      = 32'h0;
    logic [2:0]  in_rm     = 3'd0;
    logic        in_ready;
    logic [31:0] pu_a, pu_b, pu_x;
    logic [2:0]  pu_rm;
    logic        pu_stall;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  inflight;

    logic [31:0] add_s1 = 32'h0;
    logic [31:0] add_s2 = 32'h0;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    fp_add_stall_ctrl #(
        .LAT    (2),
        .DATA_W (32)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_rm     (in_rm),
        .pu_a      (pu_a),
        .pu_b      (pu_b),
        .pu_rm     (pu_rm),
        .pu_stall  (pu_stall),
        .pu_x      (pu_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .inflight  (inflight)
    );

    // Normal-number adder via double precision; exact for the small sums used here.
    function automatic real sp_to_real(input logic [31:0] v);
        logic [63:0] bits;
        if (v[30:23] == 8'h00) return 0.0;
        bits = {v[31], 11'({3'b000, v[30:23]}) + 11'd896, v[22:0], 29'd0};
        return $bitstoreal(bits);
    endfunction

    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] bits;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        bits = $realtobits(r);
        e    = bits[62:52] - 11'd896;
        return {bits[63], e[7:0], bits[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic a_sp, b_sp;
        a_sp = (a[30:23] == 8'hFF);
        b_sp = (b[30:23] == 8'hFF);
        if (a_sp || b_sp) begin
            if ((a_sp && a[22:0] != 23'd0) || (b_sp && b[22:0] != 23'd0)) return 32'h7FC00000;
            if (a_sp && b_sp && (a[31] != b[31])) return 32'h7FC00000;
            return a_sp ? a : b;
        end
        return real_to_sp(sp_to_real(a) + sp_to_real(b));
    endfunction

    always @(posedge aclk) begin
        if (!pu_stall) begin
            add_s1 <= fp_add(pu_a, pu_b);
            add_s2 <= add_s1;
        end
    end
    assign pu_x = add_s2;

    logic [31:0] b2b_a [8] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40800000,
                               32'h40400000, 32'h41000000, 32'h3F000000, 32'h40800000};
    logic [31:0] b2b_b [8] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000,
                               32'h40400000, 32'hBF800000, 32'h3F800000, 32'h40800000};
    logic [31:0] b2b_s [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                               32'h40C00000, 32'h40E00000, 32'h3FC00000, 32'h41000000};

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic test_reset();
        areset    = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 32'h3F800000, 32'h40000000);
        step();
        step();
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (pu_stall !== 1'b0) begin bad++; $display("FAIL reset_pu_stall got=%b want=0", pu_stall); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        total++; if (inflight !== 4'd0) begin bad++; $display("FAIL reset_inflight got=%0d want=0", inflight); end
        total++; if (pu_a !== 32'h3F800000) begin bad++; $display("FAIL pu_a_pass got=%h want=3f800000", pu_a); end
        areset = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        total++; if (inflight !== 4'd0) begin bad++; $display("FAIL reset_ignore_in inflight got=%0d want=0", inflight); end
        step();
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_ignore_in out_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_rm     = RM_RNE;
        drive(1'b1, 32'h3F800000, 32'h40000000);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready got=%b want=1", in_ready); end
        step();
        drive(1'b0, 32'h0, 32'h0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_t1_valid got=%b want=0", out_valid); end
        total++; if (inflight !== 4'd1) begin bad++; $display("FAIL single_t1_inflight got=%0d want=1", inflight); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_t2_valid got=%b want=0", out_valid); end
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_t3_valid got=%b want=1", out_valid); end
        total++; if (out_data !== 32'h40400000) begin bad++; $display("FAIL single_data got=%h want=40400000", out_data); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_t4_valid got=%b want=0", out_valid); end
        total++; if (inflight !== 4'd0) begin bad++; $display("FAIL single_t4_inflight got=%0d want=0", inflight); end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) drive(1'b1, b2b_a[i], b2b_b[i]);
            else       drive(1'b0, 32'h0, 32'h0);
            #1;
            if (i < 8) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", i, in_ready); end
            end
            if (out_valid === 1'b1) begin
                total++;
                if (idx >= 8) begin
                    bad++; $display("FAIL b2b_extra cyc=%0d got=%h want=none", i, out_data);
                end else if (out_data !== b2b_s[idx] || i != idx + 3) begin
                    bad++; $display("FAIL b2b_result n=%0d cyc=%0d got=%h want=%h at cyc %0d", idx, i, out_data, b2b_s[idx], idx + 3);
                end
                idx++;
            end else if (i >= 3 && i < 11) begin
                total++; bad++; $display("FAIL b2b_gap cyc=%0d got=out_valid 0 want=1", i);
            end
            step();
        end
        total++; if (idx != 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", idx); end
        total++; if (inflight !== 4'd0) begin bad++; $display("FAIL b2b_inflight got=%0d want=0", inflight); end
    endtask

    task automatic test_backpressure();
        logic [31:0] bp_a [3] = '{32'h3F800000, 32'h40000000, 32'h40400000};
        logic [31:0] bp_s [3] = '{32'h40A00000, 32'h40C00000, 32'h40E00000};
        int idx = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, bp_a[i], 32'h40800000);
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_issue_ready op=%0d got=%b want=1", i, in_ready); end
            step();
        end
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 32'h41200000, 32'h41200000);
            #1;
            total++; if (pu_stall !== 1'b1) begin bad++; $display("FAIL bp_stall cyc=%0d got=%b want=1", c, pu_stall); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", c, in_ready); end
            total++; if (inflight !== 4'd3) begin bad++; $display("FAIL bp_inflight cyc=%0d got=%0d want=3", c, inflight); end
            total++; if (out_data !== bp_s[0]) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", c, out_data, bp_s[0]); end
            step();
        end
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        #1;
        total++; if (pu_stall !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", pu_stall); end
        total++; if (inflight !== 4'd3) begin bad++; $display("FAIL bp_no_accept_in_stall got=%0d want=3", inflight); end
        for (int j = 0; j < 6; j++) begin
            if (out_valid === 1'b1) begin
                total++;
                if (idx >= 3) begin
                    bad++; $display("FAIL bp_extra got=%h want=none", out_data);
                end else if (out_data !== bp_s[idx]) begin
                    bad++; $display("FAIL bp_order n=%0d got=%h want=%h", idx, out_data, bp_s[idx]);
                end
                idx++;
            end
            step();
        end
        total++; if (idx != 3) begin bad++; $display("FAIL bp_count got=%0d want=3", idx); end
        total++; if (inflight !== 4'd0) begin bad++; $display("FAIL bp_drain got=%0d want=0", inflight); end
    endtask

    task automatic test_simul_consume_load();
        logic [31:0] sc_a [4] = '{32'h40C00000, 32'h41000000, 32'h40A00000, 32'h3FC00000};
        logic [31:0] sc_s [4] = '{32'h41400000, 32'h41800000, 32'h41200000, 32'h40400000};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, sc_a[i], sc_a[i]);
            step();
        end
        drive(1'b1, sc_a[3], sc_a[3]);
        #1;
        total++; if (out_valid !== 1'b1 || out_data !== sc_s[0]) begin bad++; $display("FAIL sc_t3 got=%b/%h want=1/%h", out_valid, out_data, sc_s[0]); end
        total++; if (inflight !== 4'd3) begin bad++; $display("FAIL sc_t3_inflight got=%0d want=3", inflight); end
        step();
        drive(1'b0, 32'h0, 32'h0);
        total++; if (out_valid !== 1'b1 || out_data !== sc_s[1]) begin bad++; $display("FAIL sc_t4 got=%b/%h want=1/%h", out_valid, out_data, sc_s[1]); end
        total++; if (inflight !== 4'd3) begin bad++; $display("FAIL sc_t4_inflight got=%0d want=3", inflight); end
        step();
        total++; if (out_data !== sc_s[2] || inflight !== 4'd2) begin bad++; $display("FAIL sc_t5 got=%h/%0d want=%h/2", out_data, inflight, sc_s[2]); end
        step();
        total++; if (out_data !== sc_s[3] || inflight !== 4'd1) begin bad++; $display("FAIL sc_t6 got=%h/%0d want=%h/1", out_data, inflight, sc_s[3]); end
        step();
        total++; if (out_valid !== 1'b0 || inflight !== 4'd0) begin bad++; $display("FAIL sc_t7 got=%b/%0d want=0/0", out_valid, inflight); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive(1'b1, 32'h3F800000, 32'h3F800000);
        step();
        drive(1'b1, 32'h40000000, 32'h40000000);
        step();
        drive(1'b1, 32'h40400000, 32'h40400000);
        areset = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1 || pu_stall !== 1'b0) begin bad++; $display("FAIL rm_during got=%b/%b want=1/0", in_ready, pu_stall); end
        step();
        areset = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        total++; if (out_valid !== 1'b0 || inflight !== 4'd0) begin bad++; $display("FAIL rm_after got=%b/%0d want=0/0", out_valid, inflight); end
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (out_valid !== 1'b0 || inflight !== 4'd0) begin bad++; $display("FAIL rm_stale cyc=%0d got=%b/%0d want=0/0", k, out_valid, inflight); end
        end
        // Reset while the adder is frozen must release the stall immediately.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h3F800000, 32'h3F800000);
            step();
        end
        drive(1'b0, 32'h0, 32'h0);
        #1;
        total++; if (pu_stall !== 1'b1) begin bad++; $display("FAIL rm_stall_setup got=%b want=1", pu_stall); end
        areset = 1'b1;
        #1;
        total++; if (pu_stall !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rm_stall_release got=%b/%b want=0/1", pu_stall, in_ready); end
        step();
        areset = 1'b0;
        total++; if (out_valid !== 1'b0 || inflight !== 4'd0) begin bad++; $display("FAIL rm_stall_clear got=%b/%0d want=0/0", out_valid, inflight); end
    endtask

    task automatic test_special();
        out_ready = 1'b1;
        in_rm     = RM_RUP;
        drive(1'b1, 32'h7F800000, 32'hFF800000);
        #1;
        total++; if (pu_rm !== 3'd2 || pu_b !== 32'hFF800000) begin bad++; $display("FAIL sp_pass got=%0d/%h want=2/ff800000", pu_rm, pu_b); end
        step();
        drive(1'b0, 32'h0, 32'h0);
        step();
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sp_valid got=%b want=1", out_valid); end
        total++; if (out_data[30:23] !== 8'hFF || out_data[22:0] === 23'd0) begin bad++; $display("FAIL sp_nan got=%h want=NaN", out_data); end
        step();
        total++; if (inflight !== 4'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL sp_drain got=%0d/%b want=0/0", inflight, out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_simul_consume_load();
        test_reset_mid();
        test_special();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
